mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, 24-bit-wide synchronous memory between two requesters: the fetch stage (instruction reads) and the execution/memory stage (data loads/stores).
- Non-pipelined: at most one access is in flight.
- Data has priority over fetch. A starvation guard is optional.
- Drives stall signals back to the pipeline while each requester waits.

Parameters:
- ADDR_W, 24, address width.
- DATA_W, 24, data width.
- MEM_LAT, 2, memory read latency in cycles; legal range 1 to 15.
- STARVE_MAX, 4, number of consecutive fetch losses before fetch is forced to win; legal range 1 to 15; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request (level).
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch granted this cycle.
- if_done  out  1  fetch access complete; one-cycle pulse.
- if_rdata  out  DATA_W  fetch read data; valid when if_done=1.
- dm_req  in  1  data request (level).
- dm_we  in  1  data request is a store.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  data granted this cycle.
- dm_done  out  1  data access complete; one-cycle pulse.
- dm_rdata  out  DATA_W  load data; valid when dm_done=1; 0 for stores.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last enabled cycle.
- stall_fetch  out  1  equals if_req and not if_done.
- stall_mem  out  1  equals dm_req and not dm_done.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; mem_en, mem_we, mem_addr, mem_wdata all 0; starvation counter 0; if_done and dm_done 0.
- State machine: IDLE and BUSY. A down-counter cnt tracks the BUSY cycles.
- IDLE:
  - Grant decision is combinational. The winner's gnt is high in this cycle T.
  - On the edge ending T, the winner's addr, we and wdata are registered onto mem_*. Owner is recorded, cnt is set to MEM_LAT-1, and the state moves to BUSY.
  - With no request, the block stays in IDLE.
- BUSY:
  - mem_en=1 and mem_* are held stable for exactly MEM_LAT cycles, T+1 to T+MEM_LAT.
  - cnt decrements each cycle.
  - When cnt==0, the owner's done pulses in that cycle (T+MEM_LAT). For a read, the owner's rdata equals mem_rdata in that cycle. For a store, rdata is 0.
  - The next state is IDLE. mem_en and mem_we are 0 in IDLE.
- Throughput: one access per MEM_LAT+1 cycles. The mandatory IDLE cycle between accesses is never skipped.
- Priority: dm_req wins over if_req, except when the starvation guard forces fetch (see Optional Feature).
- Requester protocol:
  - req, addr, we and wdata must stay stable from request until done, inclusive.
  - Dropping req before gnt withdraws the request.
  - Dropping req after gnt is ignored; the access completes and done still pulses.
  - req high in the cycle after done counts as a new request.
- stall_fetch and stall_mem are combinational. A requester that is not granted keeps its stall high.
- gnt is never asserted in BUSY. At most one gnt is high per cycle.
- Reset during BUSY:
  - The next cycle is IDLE with mem_en=0, and no done is issued for the abandoned access.
  - Whether a store took effect is the memory's concern.
  - Requesters re-request after reset.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter starve increments at each IDLE decision where data wins while if_req=1.
  - It clears when fetch is granted, or at any IDLE decision with if_req=0.
  - When starve==STARVE_MAX and both requesters are active, fetch wins.
- Undefined: strict data priority, no counter logic, STARVE_MAX is ignored, and fetch may starve indefinitely.

Test Plan:
1. Reset -> all mem_*, gnt, done and stall outputs 0; state IDLE. Release reset with no requests -> mem_en stays 0 for 10 cycles.
2. MEM_LAT=2: if_req with if_addr=0x000007 at T0, memory word 7 = 0xA5A5A5 -> if_gnt at T0; mem_en=1 and mem_addr=7 at T1-T2; if_done=1 with if_rdata=0xA5A5A5 at T2; stall_fetch=1 at T0-T1 and 0 at T2.
3. Both requests at T0 (dm load at addr 3, if at addr 8) -> dm_gnt T0, dm_done T2, IDLE T3, if_gnt T3, if_done T5; stall_fetch high T0-T4.
4. Store: dm_we=1, dm_addr=3, dm_wdata=0x00000F -> mem_we=1 at T1-T2 with mem_wdata=0x00000F; dm_done T2 with dm_rdata=0. A following load of addr 3 returns 0x00000F.
5. Starvation, STARVE_MAX=2, dm_req and if_req held continuously (dm re-requests every access):
   - With ARB_STARVE_GUARD_EN: grant sequence dm, dm, if, dm, dm, if.
   - Without the macro: only dm is granted over 12 accesses.
6. reset=1 at T1 of a fetch access -> mem_en=0 at T2; no if_done. After reset deasserts with if_req held -> a new if_gnt is issued in the first IDLE cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Non-pipelined arbiter sharing one single-port synchronous memory between fetch and data requesters.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 24,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_fetch,
    output logic              stall_mem
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
            $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must lie in 1..15");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_dm_q, owner_dm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_win, dm_win, force_if, last_cycle;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_q, starve_d;

    assign force_if = (starve_q == STARVE_LIM) && if_req && dm_req;
`else
    assign force_if = 1'b0;
`endif

    // Grants are decided only in IDLE and suppressed while reset is asserted.
    always_comb begin
        if_win = 1'b0;
        dm_win = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (dm_req && !force_if) begin
                dm_win = 1'b1;
            end else if (if_req) begin
                if_win = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_dm_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_dm_q <= owner_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q   <= starve_d;
`endif
        end
    end

    // NOTE: every combinational output gets a hold-value default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_dm_d = owner_dm_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (if_win || dm_win) begin
                    state_d    = BUSY;
                    cnt_d      = LAT_LAST;
                    owner_dm_d = dm_win;
                    we_d       = dm_win && dm_we;
                    addr_d     = dm_win ? dm_addr : if_addr;
                    wdata_d    = dm_win ? dm_wdata : '0;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_STARVE_GUARD_EN
    // Counts consecutive IDLE decisions that fetch lost while it was requesting.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (if_win || !if_req) begin
                starve_d = '0;
            end else if (dm_win) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end
`endif

    always_comb begin
        mem_en      = (state_q == BUSY);
        mem_we      = mem_en && we_q;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        if_gnt      = if_win;
        dm_gnt      = dm_win;
        last_cycle  = mem_en && (cnt_q == 4'd0) && !reset;
        if_done     = last_cycle && !owner_dm_q;
        dm_done     = last_cycle && owner_dm_q;
        if_rdata    = if_done ? mem_rdata : '0;
        dm_rdata    = (dm_done && !we_q) ? mem_rdata : '0;
        stall_fetch = if_req && !if_done;
        stall_mem   = dm_req && !dm_done;
    end

endmodule
